// File: rtl/md_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_sched_pkg
// Description : Shared types and constants for the mult/div scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package md_sched_pkg;

    localparam int unsigned MD_TIMEOUT  = 40;
    localparam int unsigned WDOG_W      = 6;

    localparam logic [4:0]  RSTATUS_REG = 5'd30;
    localparam logic [31:0] MULT_EXC    = 32'd4;
    localparam logic [31:0] DIV_EXC     = 32'd5;
    localparam logic [31:0] TIMEOUT_EXC = 32'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } md_state_e;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } rf_wr_t;

endpackage
`default_nettype wire

// File: rtl/md_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : md_sched_if
// Description : Pipeline, multdiv-unit and regfile signals of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface md_sched_if;

    logic        x_is_md;
    logic        x_is_div;
    logic [4:0]  x_rd;
    logic        md_start_mult;
    logic        md_start_div;
    logic        md_rdy;
    logic [31:0] md_result;
    logic        md_exception;
    logic        stall_md;
    logic        w_we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        md_timeout;

    modport master (
        output x_is_md, x_is_div, x_rd,
        output md_rdy, md_result, md_exception,
        output w_we, w_addr, w_data,
        input  md_start_mult, md_start_div, stall_md,
        input  rf_we, rf_addr, rf_data, md_timeout
    );

    modport slave (
        input  x_is_md, x_is_div, x_rd,
        input  md_rdy, md_result, md_exception,
        input  w_we, w_addr, w_data,
        output md_start_mult, md_start_div, stall_md,
        output rf_we, rf_addr, rf_data, md_timeout
    );

endinterface
`default_nettype wire

// File: rtl/md_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : md_watchdog
// Description : Busy-cycle counter; expires on the LIMIT-th enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module md_watchdog #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned LIMIT = 40
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expire
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Count holds the number of enabled cycles already elapsed.
    assign o_expire = i_enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
// Module      : md_sched
// Description : Sequences mult/div operations and arbitrates the regfile port.
// Revision    : 1.0 - initial release
// ============================================================================
module md_sched
    import md_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MD_TIMEOUT
) (
    input  wire logic clock,
    input  wire logic reset,
    md_sched_if.slave bus
);

    md_state_e   r_state;
    md_state_e   w_next_state;
    logic [4:0]  r_rd;
    logic        r_is_div;
    rf_wr_t      r_buf;
    rf_wr_t      w_commit;
    logic        r_timeout;
    logic        w_start;
    logic        w_busy;
    logic        w_expire;
    logic        w_done;

    assign w_start = (r_state == ST_IDLE) && bus.x_is_md;
    assign w_busy  = (r_state == ST_BUSY);
    assign w_done  = w_busy && (bus.md_rdy || w_expire);

    md_watchdog #(
        .WIDTH (WDOG_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clock),
        .rst      (reset),
        .i_clear  (w_start),
        .i_enable (w_busy),
        .o_expire (w_expire)
    );

    // md_rdy wins over a coincident expiry.
    always_comb begin
        w_commit = '0;
        if (bus.md_rdy) begin
            if (bus.md_exception) begin
                w_commit.we   = 1'b1;
                w_commit.addr = RSTATUS_REG;
                w_commit.data = r_is_div ? DIV_EXC : MULT_EXC;
            end else begin
                w_commit.we   = (r_rd != 5'd0);
                w_commit.addr = r_rd;
                w_commit.data = bus.md_result;
            end
        end else begin
            w_commit.we   = 1'b1;
            w_commit.addr = RSTATUS_REG;
            w_commit.data = TIMEOUT_EXC;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (bus.x_is_md) w_next_state = ST_BUSY;
            ST_BUSY: if (w_done)      w_next_state = bus.w_we ? ST_HOLD : ST_IDLE;
            ST_HOLD: if (!bus.w_we)   w_next_state = ST_IDLE;
            default:                  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.md_start_mult = 1'b0;
        bus.md_start_div  = 1'b0;
        bus.stall_md      = 1'b0;
        bus.rf_we         = bus.w_we;
        bus.rf_addr       = bus.w_addr;
        bus.rf_data       = bus.w_data;
        case (r_state)
            ST_IDLE: begin
                bus.md_start_mult = bus.x_is_md & ~bus.x_is_div;
                bus.md_start_div  = bus.x_is_md &  bus.x_is_div;
                bus.stall_md      = bus.x_is_md;
            end
            ST_BUSY: begin
                bus.stall_md = 1'b1;
                if (w_done && !bus.w_we) begin
                    bus.rf_we   = w_commit.we;
                    bus.rf_addr = w_commit.addr;
                    bus.rf_data = w_commit.data;
                end
            end
            ST_HOLD: begin
                bus.stall_md = 1'b1;
                if (!bus.w_we) begin
                    bus.rf_we   = r_buf.we;
                    bus.rf_addr = r_buf.addr;
                    bus.rf_data = r_buf.data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd      <= 5'd0;
            r_is_div  <= 1'b0;
            r_buf     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_start) begin
                r_rd     <= bus.x_rd;
                r_is_div <= bus.x_is_div;
            end
            if (w_done && bus.w_we) begin
                r_buf <= w_commit;
            end
            if (w_busy && w_expire && !bus.md_rdy) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.md_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_sched
// Description : Randomized scoreboard bench for md_sched against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_sched;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    md_sched_if bus();

    md_sched dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  cyc    = 0;

    // Reference model: operation in flight, its age, and a parked result.
    bit          m_busy = 0;
    bit          m_pend = 0;
    bit          m_tmo  = 0;
    bit          m_is_div = 0;
    int          m_age  = 0;
    logic [4:0]  m_rd   = 5'd0;
    bit          m_pend_we = 0;
    logic [4:0]  m_pend_addr = 5'd0;
    logic [31:0] m_pend_data = 32'd0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic push_wr(logic [4:0] a, logic [31:0] d);
        wr_t e;
        e.cyc  = cyc;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive_cycle(bit md, bit dv, logic [4:0] rd, bit rdy,
                               logic [31:0] res, bit exc, bit we,
                               logic [4:0] wa, logic [31:0] wd);
        bit          idle;
        bit          done;
        bit          c_we;
        logic [4:0]  c_addr;
        logic [31:0] c_data;
        @(negedge clk);
        cyc++;
        reset            = 1'b0;
        bus.x_is_md      = md;
        bus.x_is_div     = dv;
        bus.x_rd         = rd;
        bus.md_rdy       = rdy;
        bus.md_result    = res;
        bus.md_exception = exc;
        bus.w_we         = we;
        bus.w_addr       = wa;
        bus.w_data       = wd;
        #2;
        idle = !m_busy && !m_pend;
        check("stall_md",   {31'd0, bus.stall_md},      {31'd0, (m_busy || m_pend || md)});
        check("start_mult", {31'd0, bus.md_start_mult}, {31'd0, (idle && md && !dv)});
        check("start_div",  {31'd0, bus.md_start_div},  {31'd0, (idle && md && dv)});
        check("md_timeout", {31'd0, bus.md_timeout},    {31'd0, m_tmo});
        done   = 0;
        c_we   = 0;
        c_addr = 5'd0;
        c_data = 32'd0;
        if (m_busy) begin
            if (rdy) begin
                done = 1;
                if (exc) begin
                    c_we = 1; c_addr = 5'd30; c_data = m_is_div ? 32'd5 : 32'd4;
                end else begin
                    c_we = (m_rd != 5'd0); c_addr = m_rd; c_data = res;
                end
            end else if (m_age + 1 == 40) begin
                done = 1; m_tmo = 1;
                c_we = 1; c_addr = 5'd30; c_data = 32'd6;
            end
        end
        if (we) push_wr(wa, wd);
        if (done) begin
            if (we) begin
                m_pend = 1; m_pend_we = c_we; m_pend_addr = c_addr; m_pend_data = c_data;
            end else if (c_we) begin
                push_wr(c_addr, c_data);
            end
        end else if (m_pend && !we) begin
            if (m_pend_we) push_wr(m_pend_addr, m_pend_data);
            m_pend = 0;
        end
        if (m_busy) begin
            if (done) m_busy = 0;
            else      m_age++;
        end else if (idle && md) begin
            m_busy = 1; m_age = 0; m_is_div = dv; m_rd = rd;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        reset            = 1'b1;
        bus.x_is_md      = 1'b0;
        bus.md_rdy       = 1'b0;
        bus.md_exception = 1'b0;
        bus.w_we         = 1'b0;
        m_busy = 0; m_pend = 0; m_tmo = 0; m_age = 0;
    endtask

    task automatic idle_cycle();
        drive_cycle(0, 0, 5'd0, 1'($urandom_range(0, 1)), $urandom, 0,
                    1'($urandom_range(0, 1)), 5'($urandom), $urandom);
    endtask

    // wmode 0: W idle, 1: random W traffic, 2: W writes r3 on BUSY cycles lat and lat+1
    task automatic run_op(bit dv, logic [4:0] rd, int lat, bit exc,
                          logic [31:0] res, int wmode);
        bit we;
        bit rdy;
        drive_cycle(1, dv, rd, 0, 32'd0, 0, 0, 5'd0, 32'd0);
        for (int k = 1; k <= 100; k++) begin
            if (!m_busy && !m_pend) return;
            if (wmode == 1)      we = ($urandom_range(0, 2) == 0);
            else if (wmode == 2) we = (k == lat) || (k == lat + 1);
            else                 we = 0;
            rdy = (k == lat) || (m_pend && ($urandom_range(0, 1) == 1));
            drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
                        rdy, res, exc, we,
                        (wmode == 2) ? 5'd3 : 5'($urandom), $urandom);
        end
        n_cmp++;
        n_fail++;
        $display("FAIL op_complete cyc=%0d got=busy want=idle", cyc);
    endtask

    // Monitor: every regfile write must match the oldest expected write and its cycle.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #3;
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL rf_missing cyc=%0d got=none want=r%0d<=%h", e.cyc, e.addr, e.data);
            end
            if (reset === 1'b0 && bus.rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rf_unexpected cyc=%0d got=r%0d<=%h want=none",
                             cyc, bus.rf_addr, bus.rf_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rf_cycle", cyc, e.cyc);
                    check("rf_addr", {27'd0, bus.rf_addr}, {27'd0, e.addr});
                    check("rf_data", bus.rf_data, e.data);
                end
            end
        end
    end

    initial begin
        bus.x_is_md = 0; bus.x_is_div = 0; bus.x_rd = 0;
        bus.md_rdy = 0; bus.md_result = 0; bus.md_exception = 0;
        bus.w_we = 0; bus.w_addr = 0; bus.w_data = 0;
        repeat (2) @(negedge clk);

        drive_cycle(0, 0, 5'd0, 0, 32'd0, 0, 0, 5'd0, 32'd0);
        drive_cycle(0, 0, 5'd0, 1, 32'd0, 0, 1, 5'd9, 32'h1234_5678);

        run_op(0, 5'd5, 32, 0, 32'hCAFE_0005, 0);
        idle_cycle();
        run_op(1, 5'd7, 20, 0, 32'hD1D0_0007, 2);
        idle_cycle();
        run_op(1, 5'd11, 5, 1, 32'hAAAA_AAAA, 0);
        run_op(0, 5'd11, 5, 1, 32'hBBBB_BBBB, 0);
        run_op(0, 5'd0, 8, 0, 32'hFFFF_FFFF, 0);
        run_op(0, 5'd0, 8, 0, 32'hEEEE_EEEE, 2);
        idle_cycle();

        run_op(0, 5'd12, 0, 0, 32'd0, 0);
        idle_cycle();
        idle_cycle();
        do_reset();
        idle_cycle();

        drive_cycle(1, 0, 5'd9, 0, 32'd0, 0, 0, 5'd0, 32'd0);
        for (int k = 1; k <= 9; k++) drive_cycle(0, 0, 5'd0, 0, 32'd0, 0, 0, 5'd0, 32'd0);
        do_reset();
        for (int k = 11; k <= 34; k++)
            drive_cycle(0, 0, 5'd0, (k == 32), 32'hDEAD_BEEF, 0, 0, 5'd0, 32'd0);

        run_op(1, 5'd14, 4, 0, 32'h0000_1111, 2);
        do_reset();

        for (int t = 0; t < 40; t++) begin
            run_op(1'($urandom_range(0, 1)), 5'($urandom), $urandom_range(1, 44),
                   ($urandom_range(0, 5) == 0), $urandom, 1);
            for (int i = 0; i < $urandom_range(0, 3); i++) idle_cycle();
        end

        drive_cycle(0, 0, 5'd0, 0, 32'd0, 0, 0, 5'd0, 32'd0);
        @(negedge clk);
        #4;
        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 Port clock, input, 1: master clock; all state updates on its rising edge.
REQ-002 Port reset, input, 1: synchronous, active-high reset.
REQ-003 Port x_is_md, input, 1: the X-stage instruction is a mult or div.
REQ-004 Port x_is_div, input, 1: 1 means div, 0 means mult; valid only with x_is_md.
REQ-005 Port x_rd, input, 5: destination register of the X-stage mult/div.
REQ-006 Ports md_start_mult and md_start_div, output, 1 each: start pulses to the multdiv unit.
REQ-007 Ports md_rdy (input, 1), md_result (input, 32), md_exception (input, 1): multdiv completion.
REQ-008 Port stall_md, output, 1: freezes PC, FD and DX, and bubbles XM.
REQ-009 Ports w_we (input, 1), w_addr (input, 5), w_data (input, 32): pipeline W-stage write request.
REQ-010 Ports rf_we (output, 1), rf_addr (output, 5), rf_data (output, 32): arbitrated regfile write port.
REQ-011 Port md_timeout, output, 1: sticky watchdog flag.

Function
REQ-012 The block SHALL have three states: IDLE, BUSY (unit computing) and HOLD (result buffered, waiting for the write port).
REQ-013 In IDLE with x_is_md=1, md_start_div=x_is_div and md_start_mult=~x_is_div, combinationally, for exactly that one cycle.
- Same cycle: latch x_rd and x_is_div.
- Next state: BUSY.
REQ-014 stall_md = (IDLE & x_is_md) | BUSY | HOLD; it SHALL never deassert before the result is committed.
REQ-015 Start pulses SHALL be 0 in BUSY and HOLD; x_is_md in those states is ignored.
REQ-016 md_rdy in IDLE or HOLD SHALL be ignored.
REQ-017 The pipeline W stage SHALL have priority on the write port.
- When W wins: rf_we=w_we, rf_addr=w_addr, rf_data=w_data.
REQ-018 BUSY with md_rdy=1 and w_we=0: write the result the same cycle and go to IDLE; stall_md is 0 in the following cycle.
REQ-019 BUSY with md_rdy=1 and w_we=1: drive the W write; capture addr and data into a one-entry buffer; go to HOLD.
REQ-020 HOLD with w_we=0: drive the buffered write and go to IDLE; HOLD with w_we=1: stay in HOLD.
REQ-021 Commit data for a normal result: addr=latched rd, data=md_result.
REQ-022 Commit data for md_exception=1: addr=30, data=4 for mult or 5 for div.
REQ-023 A normal result with rd=0 SHALL complete the handshake with rf_we=0.
REQ-024 The watchdog SHALL count BUSY cycles in a 6-bit counter, cleared on entry to BUSY.
- At MD_TIMEOUT (default 40) cycles without md_rdy: set md_timeout, commit addr=30, data=6 under the priority rules, return to IDLE.
REQ-025 In IDLE, rf_* SHALL mirror the w_* inputs.

Reset
REQ-026 While reset=1 the block SHALL force the following at the next edge:
- State IDLE; buffer, latched rd and watchdog cleared.
- md_timeout=0.
- Start pulses 0; stall_md driven only by the IDLE equation.
REQ-027 A reset mid-BUSY or mid-HOLD SHALL discard the in-flight result; a later md_rdy is ignored.

Structure
REQ-028 Package md_sched_pkg SHALL hold:
- The state enum.
- RSTATUS_REG=30, MULT_EXC=4, DIV_EXC=5, TIMEOUT_EXC=6.
- MD_TIMEOUT default.
REQ-029 The watchdog counter SHALL be a sub-module, md_watchdog (clear, enable, expire outputs).

Verification
REQ-030 Mult, rd=5, md_rdy after 32 cycles, w_we=0 -> one start_mult pulse; stall 33 cycles; rf r5=result; stall low the next cycle.
REQ-031 Div, rd=7, md_rdy coincident with w_we=1 (w_addr=3) for 2 cycles -> r3 written first, HOLD 2 cycles, then r7 written; stall held throughout.
REQ-032 Div with md_exception=1 -> rf_addr=30, rf_data=5; the mult variant gives rf_data=4.
REQ-033 Mult with rd=0 -> rf_we=0 at completion; returns to IDLE.
REQ-034 md_rdy never asserted -> md_timeout=1 after 40 BUSY cycles, r30=6, IDLE.
REQ-035 Reset at BUSY cycle 10, then md_rdy at cycle 32 -> no write, stall_md=0, state IDLE.
